// File: rtl/noc_node_tx_pkg.sv
// Shared NoC configuration: mesh size, packet layout and timestamp width.
// Also holds the injection-port FSM state encoding.
package noc_node_tx_pkg;

    localparam int X_NODES  = 4;
    localparam int Y_NODES  = 4;
    localparam int NODES    = X_NODES * Y_NODES;
    localparam int PORTS    = 5;
    localparam int ADDR_W   = $clog2(NODES);
    localparam int TS_WIDTH = 32;
    localparam int DATA_W   = 32;

    typedef struct packed {
        logic [DATA_W-1:0]   data;
        logic [ADDR_W-1:0]   source;
        logic [ADDR_W-1:0]   dest;
        logic [TS_WIDTH-1:0] timestamp;
        logic                valid;
    } packet_t;

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_READY,
        ST_BLOCKED,
        ST_STALLED
    } tx_state_e;

endpackage

// File: rtl/noc_tx_fifo.sv
// Synchronous packet FIFO with registered full/nearly-full flags.
// Head is read straight from storage, so a pushed entry is visible one cycle later.
module noc_tx_fifo
    import noc_node_tx_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic    clk,
    input  logic    reset_n,
    input  logic    i_push,
    input  packet_t i_data,
    input  logic    i_pop,
    output packet_t o_head,
    output logic    o_full,
    output logic    o_nearly_full,
    output logic    o_empty,
    output logic    o_empty_next
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_C = (AW + 1)'(DEPTH);
    localparam logic [AW:0] NF_C   = (AW + 1)'(DEPTH - 1);

    packet_t       r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          r_full;
    logic          r_nearly_full;

    logic          w_push;
    logic          w_pop;
    logic [AW:0]   w_count_next;

    assign w_push = i_push && !r_full;
    assign w_pop  = i_pop && (r_count != '0);

    // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        w_count_next = r_count;
        if (w_push && !w_pop) begin
            w_count_next = r_count + 1'b1;
        end else if (!w_push && w_pop) begin
            w_count_next = r_count - 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_count       <= '0;
            r_full        <= 1'b0;
            r_nearly_full <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count       <= w_count_next;
            r_full        <= (w_count_next == FULL_C);
            r_nearly_full <= (w_count_next >= NF_C);
        end
    end

    // NOTE: storage is not reset; the cleared pointers alone decide which entries are live.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_data;
    end

    assign o_head        = r_mem[r_rd_ptr];
    assign o_full        = r_full;
    assign o_nearly_full = r_nearly_full;
    assign o_empty       = (r_count == '0);
    assign o_empty_next  = (w_count_next == '0);

endmodule

// File: rtl/noc_node_tx.sv
// Per-node injection port: queues source packets, stamps source ID and injection
// time, and offers them to the network only while its enable is high.
module noc_node_tx
    import noc_node_tx_pkg::*;
#(
    parameter int NODE_ID     = 0,
    parameter int DEPTH       = 4,
    parameter int TS_W        = 32,
    parameter int CNT_W       = 32,
    parameter int STALL_LIMIT = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  packet_t          i_pkt,
    output logic             o_full,
    output logic             o_nearly_full,
    output packet_t          o_data,
    output logic             o_data_val,
    input  logic             i_en,
    output logic [CNT_W-1:0] o_sent_count,
    output logic             o_stalled
);

    localparam int SC_W = $clog2(STALL_LIMIT + 1);
    localparam logic [SC_W-1:0]   STALL_MAX = SC_W'(STALL_LIMIT);
    localparam logic [ADDR_W-1:0] SRC_ID    = ADDR_W'(NODE_ID);

    logic [TS_W-1:0]  r_cycle;
    logic [CNT_W-1:0] r_sent;
    logic [SC_W-1:0]  r_stall_cnt;
    tx_state_e        r_state;

    tx_state_e        w_state_next;
    logic [SC_W-1:0]  w_stall_next;
    packet_t          w_stamped;
    packet_t          w_head;
    logic             w_push;
    logic             w_xfer;
    logic             w_empty;
    logic             w_empty_next;
    logic             w_full;
    logic             w_nearly_full;

    assign w_push = i_pkt.valid && !w_full;

    always_comb begin
        w_stamped           = i_pkt;
        w_stamped.source    = SRC_ID;
        w_stamped.timestamp = r_cycle;
    end

    noc_tx_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk           (clk),
        .reset_n       (reset_n),
        .i_push        (w_push),
        .i_data        (w_stamped),
        .i_pop         (w_xfer),
        .o_head        (w_head),
        .o_full        (w_full),
        .o_nearly_full (w_nearly_full),
        .o_empty       (w_empty),
        .o_empty_next  (w_empty_next)
    );

    // Gated by reset so a head caught mid-transfer is discarded rather than sent.
    assign w_xfer = reset_n && !w_empty && i_en;

    always_comb begin
        w_stall_next = r_stall_cnt;
        if (w_xfer || w_empty) begin
            w_stall_next = '0;
        end else if (!i_en && (r_stall_cnt < STALL_MAX)) begin
            w_stall_next = r_stall_cnt + 1'b1;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_EMPTY: begin
                if (w_push) w_state_next = i_en ? ST_READY : ST_BLOCKED;
            end
            ST_READY, ST_BLOCKED: begin
                if (w_empty_next)                    w_state_next = ST_EMPTY;
                else if (w_stall_next >= STALL_MAX)  w_state_next = ST_STALLED;
                else                                 w_state_next = i_en ? ST_READY : ST_BLOCKED;
            end
            ST_STALLED: begin
                if (w_xfer) w_state_next = w_empty_next ? ST_EMPTY : ST_READY;
            end
            default: w_state_next = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_cycle     <= '0;
            r_sent      <= '0;
            r_stall_cnt <= '0;
            r_state     <= ST_EMPTY;
        end else begin
            r_cycle     <= r_cycle + 1'b1;
            r_stall_cnt <= w_stall_next;
            r_state     <= w_state_next;
            if (w_xfer) r_sent <= r_sent + 1'b1;
        end
    end

    always_comb begin
        o_data       = w_head;
        o_data.valid = w_xfer;
    end

    assign o_data_val    = w_xfer;
    assign o_full        = w_full;
    assign o_nearly_full = w_nearly_full;
    assign o_sent_count  = r_sent;
    assign o_stalled     = (r_state == ST_STALLED);

endmodule

// File: tb/tb_noc_node_tx.sv
// Scoreboard bench for noc_node_tx: driver queues expected stamped packets,
// a negedge monitor pops and compares whenever the port offers a packet.
module tb_noc_node_tx;
    import noc_node_tx_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    packet_t     i_pkt;
    logic        o_full;
    logic        o_nearly_full;
    packet_t     o_data;
    logic        o_data_val;
    logic        i_en;
    logic [31:0] o_sent_count;
    logic        o_stalled;

    int          n_total  = 0;
    int          n_passed = 0;
    packet_t     exp_q[$];
    logic [31:0] model_cycle;

    noc_node_tx #(
        .NODE_ID     (2),
        .DEPTH       (4),
        .TS_W        (32),
        .CNT_W       (32),
        .STALL_LIMIT (16)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .i_pkt         (i_pkt),
        .o_full        (o_full),
        .o_nearly_full (o_nearly_full),
        .o_data        (o_data),
        .o_data_val    (o_data_val),
        .i_en          (i_en),
        .o_sent_count  (o_sent_count),
        .o_stalled     (o_stalled)
    );

    always #5 clk = ~clk;

    // Reference time base: the injection cycle number since the last reset edge.
    always @(posedge clk) begin
        if (!reset_n) model_cycle <= 32'd0;
        else          model_cycle <= model_cycle + 32'd1;
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_passed++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    always @(negedge clk) begin
        packet_t e;
        if (o_data_val) begin
            check("voq_en_high", 128'(i_en), 128'(1));
            e = '0;
            if (exp_q.size() > 0) e = exp_q.pop_front();
            check("sb_packet", 128'(o_data), 128'(e));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Drive one cycle of source/network inputs; an expected accept is queued with its stamp.
    task automatic drive(input logic v, input logic [3:0] dest, input logic [31:0] data,
                         input logic en, input logic exp_acc);
        packet_t p;
        packet_t e;
        p           = '0;
        p.valid     = v;
        p.dest      = dest;
        p.data      = data;
        p.source    = 4'hF;
        p.timestamp = 32'hDEAD_BEEF;
        i_pkt       = p;
        i_en        = en;
        if (v && exp_acc) begin
            e           = p;
            e.source    = 4'd2;
            e.timestamp = model_cycle;
            e.valid     = 1'b1;
            exp_q.push_back(e);
        end
        cyc();
    endtask

    task automatic do_reset(input logic en);
        reset_n = 1'b0;
        i_pkt   = '0;
        i_en    = en;
        #1;
        check("rst_val_during", 128'(o_data_val), 128'(0));
        @(posedge clk);
        #1;
        exp_q.delete();
        reset_n = 1'b1;
        #1;
        check("rst_full",    128'(o_full),        128'(0));
        check("rst_nfull",   128'(o_nearly_full), 128'(0));
        check("rst_val",     128'(o_data_val),    128'(0));
        check("rst_sent",    128'(o_sent_count),  128'(0));
        check("rst_stalled", 128'(o_stalled),     128'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] nf_tbl;
        logic [3:0] full_tbl;
        nf_tbl   = 4'b1100;
        full_tbl = 4'b1000;
        reset_n  = 1'b0;
        i_pkt    = '0;
        i_en     = 1'b0;
        cyc();

        // Single packet, enable high: offered exactly one cycle after accept.
        do_reset(1'b0);
        drive(1'b1, 4'd3, 32'hA001, 1'b1, 1'b1);
        check("t1_val_next_cycle", 128'(o_data_val), 128'(1));
        check("t1_sent_before",    128'(o_sent_count), 128'(0));
        drive(1'b0, 4'd0, 32'h0, 1'b1, 1'b0);
        check("t1_sent_after", 128'(o_sent_count), 128'(1));
        check("t1_val_after",  128'(o_data_val),   128'(0));
        check("t1_sb_empty",   128'(exp_q.size()), 128'(0));

        // Fill with enable low: flags, dropped 5th packet, no valid.
        do_reset(1'b0);
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 4'(i), 32'hB000 + 32'(i), 1'b0, 1'b1);
            check("t2_nfull", 128'(o_nearly_full), 128'(nf_tbl[i]));
            check("t2_full",  128'(o_full),        128'(full_tbl[i]));
            check("t2_val",   128'(o_data_val),    128'(0));
        end
        drive(1'b1, 4'd4, 32'hB004, 1'b0, 1'b0);
        check("t2_full_hold", 128'(o_full),     128'(1));
        check("t2_val_5th",   128'(o_data_val), 128'(0));

        // Keep blocked: 4 blocked cycles counted so far, 12 more reach the limit.
        for (int i = 0; i < 11; i++) begin
            drive(1'b0, 4'd0, 32'h0, 1'b0, 1'b0);
            check("t3_not_stalled", 128'(o_stalled), 128'(0));
        end
        drive(1'b0, 4'd0, 32'h0, 1'b0, 1'b0);
        check("t3_stalled", 128'(o_stalled), 128'(1));
        i_en = 1'b1;
        #1;
        check("t3_stalled_pre_xfer", 128'(o_stalled), 128'(1));
        for (int k = 0; k < 4; k++) begin
            check("t3_drain_val", 128'(o_data_val), 128'(1));
            drive(1'b0, 4'd0, 32'h0, 1'b1, 1'b0);
            if (k == 0) check("t3_stall_clear", 128'(o_stalled), 128'(0));
        end
        check("t3_val_done", 128'(o_data_val),   128'(0));
        check("t3_sent",     128'(o_sent_count), 128'(4));
        check("t3_sb_empty", 128'(exp_q.size()), 128'(0));

        // Streaming: one write and one transfer per cycle, occupancy stays at 1.
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 4'd5, 32'hC000 + 32'(i), 1'b1, 1'b1);
            check("t4_val",   128'(o_data_val),    128'(1));
            check("t4_full",  128'(o_full),        128'(0));
            check("t4_nfull", 128'(o_nearly_full), 128'(0));
        end
        drive(1'b0, 4'd0, 32'h0, 1'b1, 1'b0);
        check("t4_val_done", 128'(o_data_val),   128'(0));
        check("t4_sent",     128'(o_sent_count), 128'(12));
        check("t4_sb_empty", 128'(exp_q.size()), 128'(0));

        // Toggling enable with a continuous source: occupancy ends at 3.
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 4'd6, 32'hD000 + 32'(i), (i % 2) == 0, 1'b1);
        end
        check("t5_nfull", 128'(o_nearly_full), 128'(1));
        check("t5_full",  128'(o_full),        128'(0));
        for (int i = 0; i < 3; i++) drive(1'b0, 4'd0, 32'h0, 1'b1, 1'b0);
        check("t5_val_done", 128'(o_data_val),   128'(0));
        check("t5_sent",     128'(o_sent_count), 128'(17));
        check("t5_sb_empty", 128'(exp_q.size()), 128'(0));

        // Reset with three packets queued; none may appear afterwards.
        for (int i = 0; i < 3; i++) drive(1'b1, 4'd7, 32'hEE00 + 32'(i), 1'b0, 1'b1);
        do_reset(1'b1);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 4'd0, 32'h0, 1'b1, 1'b0);
            check("t6_no_stale", 128'(o_data_val), 128'(0));
        end
        drive(1'b1, 4'd7, 32'hE001, 1'b1, 1'b1);
        drive(1'b0, 4'd0, 32'h0, 1'b1, 1'b0);
        check("t6_sent",     128'(o_sent_count), 128'(1));
        check("t6_sb_empty", 128'(exp_q.size()), 128'(0));

        $display("%0d/%0d checks passed", n_passed, n_total);
        $finish;
    end

endmodule
